regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64: register data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, >= 4.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter INIT_IDX, default 1: 1 = entry i initialises to i (zero-extended); 0 = entries initialise to zero.
REQ-005 SHALL define localparam AW = clog2(NREG).
REQ-006 SHALL have port clk, input, 1: clock; all state updates occur on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port we0, input, 1: write-port-0 enable.
REQ-009 SHALL have port waddr0, input, AW: write-port-0 address.
REQ-010 SHALL have port wdata0, input, XLEN: write-port-0 data.
REQ-011 SHALL have ports we1, waddr1 and wdata1 with the same widths and meanings for write port 1.
REQ-012 SHALL have port raddr, input, NRD*AW: read addresses, port k at bits [k*AW +: AW].
REQ-013 SHALL have port rdata, output, NRD*XLEN: read data, port k at bits [k*XLEN +: XLEN].
REQ-014 SHALL have port ready, output, 1: high once initialisation completes.

Function
REQ-015 SHALL implement a two-state FSM: INIT and RUN.
REQ-016 SHALL hold an AW-bit init counter; entry at INIT occurs with counter = 0.
REQ-017 In INIT, each cycle SHALL write the init value of entry[counter] and increment the counter.
REQ-018 SHALL leave INIT for RUN on the cycle after entry NREG-1 is written (exactly NREG cycles in INIT).
REQ-019 ready SHALL be 0 in INIT and 1 in RUN, driven from a register.
REQ-020 In INIT, we0 and we1 SHALL be ignored, and every rdata lane SHALL read 0.
REQ-021 In RUN, a write port with weN=1 and waddrN != 0 SHALL update the entry at the rising edge.
REQ-022 Entry 0 SHALL always read 0, and any write to entry 0 SHALL be discarded.
REQ-023 If both ports write the same non-zero address in one cycle, port 1 data SHALL be stored (port 1 has priority).
REQ-024 Reads SHALL be combinational with zero latency: rdata lane k = entry[raddr k] in the same cycle.
REQ-025 Write-first bypass: in RUN, if a lane's address matches an enabled non-zero write address, that lane SHALL return the write data in the same cycle.
REQ-026 Bypass SHALL follow the REQ-023 priority: port 1 wins when both write ports match.
REQ-027 A read of address 0 SHALL return 0 even when a write to address 0 is presented.
REQ-028 All NRD read lanes SHALL be independent; any lanes may share an address.
REQ-029 Storage SHALL contain no X after INIT completes.

Reset
REQ-030 reset=1 at a rising edge SHALL force INIT, counter = 0 and ready = 0, regardless of the current state.
REQ-031 While reset is held, the FSM SHALL stay in INIT with counter 0, and no entry SHALL be written.
REQ-032 Reset mid-INIT SHALL restart initialisation from entry 0.
REQ-033 Reset mid-RUN SHALL discard writes presented in that cycle.
REQ-034 After reset deasserts, ready SHALL rise exactly NREG cycles later (cycle 32 at defaults).

Verification
REQ-035 Init: pulse reset, apply default params -> ready=0 for 32 cycles, then 1; reading x5 gives 5 and x31 gives 31; with INIT_IDX=0, x5 gives 0.
REQ-036 Write/bypass: in RUN, set we0=1, waddr0=7, wdata0=0xDEAD, raddr lane0=7 in the same cycle -> rdata0=0xDEAD that cycle and on the following cycle with we0=0.
REQ-037 Collision: we0=we1=1, both addresses 9, wdata0=0x11, wdata1=0x22 -> bypass gives 0x22; the stored value read the next cycle is 0x22.
REQ-038 x0: we1=1, waddr1=0, wdata1=0xFFFF, read lane 0 addr 0 -> 0 in that cycle and the next.
REQ-039 Writes ignored in INIT: write x3=0xAA during cycle 10 of INIT -> after ready, x3 reads 3.
REQ-040 Reset mid-RUN: write x4=0x55, then assert reset for 1 cycle alongside write x6=0x77 -> ready drops; after 32 cycles x4=4 and x6=6.
REQ-041 Parameter sweep: XLEN=32, NREG=8, NRD=3 -> ready after 8 cycles; three lanes reading addresses 1, 1 and 7 return 1, 1 and 7.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD read ports,
// write-first bypass, x0 hardwired to zero, self-initialising.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [XLEN-1:0]   wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [XLEN-1:0]   wdata1,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic              ready
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_n;
  logic            ready_q;

  logic            init_we;
  logic            run_en;
  logic            wr0;
  logic            wr1;
  logic [XLEN-1:0] init_val;

  logic [XLEN-1:0] mem [NREG];

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == RUN);
    end
  end

  // next-state logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      INIT: begin
        cnt_n = cnt + AW'(1);
        if (cnt == AW'(NREG - 1))
          state_n = RUN;
      end
      RUN: begin
        state_n = RUN;
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  // output / write-enable logic
  always_comb begin
    init_we  = (state == INIT) && !reset;
    run_en   = (state == RUN) && !reset;
    wr0      = run_en && we0 && (waddr0 != '0);
    wr1      = run_en && we1 && (waddr1 != '0);
    init_val = (INIT_IDX != 0) ? XLEN'(cnt) : '0;
  end

  assign ready = ready_q;

  // port 1 is the later assignment, so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt] <= init_val;
    end else begin
      if (wr0)
        mem[waddr0] <= wdata0;
      if (wr1)
        mem[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] rd;

    always_comb begin
      ra   = raddr[k*AW +: AW];
      hit0 = we0 && (waddr0 == ra);
      hit1 = we1 && (waddr1 == ra);
      if (state != RUN)
        rd = '0;
      else if (ra == '0)
        rd = '0;
      else if (hit1)
        rd = wdata1;
      else if (hit0)
        rd = wdata0;
      else
        rd = mem[ra];
    end

    assign rdata[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, zero-init
// and small-parameter instances driven in lockstep.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        we0;
  logic [4:0]  waddr0;
  logic [63:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [63:0] wdata1;
  logic [9:0]  raddr;
  logic [127:0] rdata_a;
  logic [127:0] rdata_b;
  logic        ready_a;
  logic        ready_b;

  logic        s_we0;
  logic [2:0]  s_waddr0;
  logic [31:0] s_wdata0;
  logic        s_we1;
  logic [2:0]  s_waddr1;
  logic [31:0] s_wdata1;
  logic [8:0]  s_raddr;
  logic [95:0] s_rdata;
  logic        s_ready;

  int checks;
  int errors;
  int cyc;
  int cyc_s;

  regfile_mp u_a (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_a), .ready(ready_a)
  );

  regfile_mp #(.INIT_IDX(0)) u_b (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_b), .ready(ready_b)
  );

  regfile_mp #(.XLEN(32), .NREG(8), .NRD(3)) u_s (
    .clk(clk), .reset(reset),
    .we0(s_we0), .waddr0(s_waddr0), .wdata0(s_wdata0),
    .we1(s_we1), .waddr1(s_waddr1), .wdata1(s_wdata1),
    .raddr(s_raddr), .rdata(s_rdata), .ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    raddr = {5'd31, 5'd5};
    s_we0 = 1'b0; s_waddr0 = '0; s_wdata0 = '0;
    s_we1 = 1'b0; s_waddr1 = '0; s_wdata1 = '0;
    s_raddr = {3'd7, 3'd1, 3'd1};

    tick();
    chk("reset_ready_a", 64'(ready_a), 64'd0);
    chk("reset_ready_s", 64'(s_ready), 64'd0);
    reset = 1'b0;

    // initialisation phase with an ignored write at cycle 10
    cyc   = 0;
    cyc_s = 0;
    while (!ready_a && cyc < 100) begin
      tick();
      cyc++;
      if (s_ready && cyc_s == 0)
        cyc_s = cyc;
      if (cyc == 10) begin
        chk("init_ready_lo", 64'(ready_a), 64'd0);
        chk("init_rd_zero", rdata_a[63:0], 64'd0);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'hAA;
      end
      if (cyc == 11)
        we0 = 1'b0;
    end
    chk("init_len_a", 64'(cyc), 64'd32);
    chk("init_len_s", 64'(cyc_s), 64'd8);
    chk("init_ready_b", 64'(ready_b), 64'd1);

    #1;
    chk("x5_a", rdata_a[63:0], 64'd5);
    chk("x31_a", rdata_a[127:64], 64'd31);
    chk("x5_b", rdata_b[63:0], 64'd0);
    chk("s_lane0", 64'(s_rdata[31:0]), 64'd1);
    chk("s_lane1", 64'(s_rdata[63:32]), 64'd1);
    chk("s_lane2", 64'(s_rdata[95:64]), 64'd7);
    raddr = {5'd3, 5'd3};
    #1;
    chk("x3_kept", rdata_a[63:0], 64'd3);

    // write with same-cycle bypass
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'hDEAD;
    raddr = {5'd1, 5'd7};
    #1;
    chk("byp_x7", rdata_a[63:0], 64'hDEAD);
    chk("byp_other", rdata_a[127:64], 64'd1);
    tick();
    we0 = 1'b0;
    #1;
    chk("stored_x7", rdata_a[63:0], 64'hDEAD);

    // same-address collision, port 1 wins
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 64'h11;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'h22;
    raddr = {5'd9, 5'd9};
    #1;
    chk("coll_byp0", rdata_a[63:0], 64'h22);
    chk("coll_byp1", rdata_a[127:64], 64'h22);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    chk("coll_store", rdata_a[63:0], 64'h22);

    // writes to x0 are dropped
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 64'hFFFF;
    raddr = {5'd9, 5'd0};
    #1;
    chk("x0_byp", rdata_a[63:0], 64'd0);
    tick();
    we1 = 1'b0;
    #1;
    chk("x0_store", rdata_a[63:0], 64'd0);

    // reset in the middle of RUN
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 64'h55;
    tick();
    we0 = 1'b0;
    raddr = {5'd6, 5'd4};
    #1;
    chk("x4_written", rdata_a[63:0], 64'h55);
    reset = 1'b1;
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 64'h77;
    tick();
    chk("rst_ready_lo", 64'(ready_a), 64'd0);
    reset = 1'b0;
    we0 = 1'b0;
    cyc = 0;
    while (!ready_a && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reinit_len", 64'(cyc), 64'd32);
    #1;
    chk("x4_reinit", rdata_a[63:0], 64'd4);
    chk("x6_reinit", rdata_a[127:64], 64'd6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
